// File: rtl/btn_debounce_if.sv
// Button conditioner bundle: raw button in, debounced level and press/release pulses out.
// The master side drives the raw button; the slave side is the debouncer.
interface btn_debounce_if;
  logic btn;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  modport master (
    output btn,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchroniser plus stability-count FSM with registered level/pulse outputs.
// Latency DEBOUNCE_CYCLES+2 edges from first sampling; no backpressure, pulses are fire-and-forget.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bif
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             btn_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_q;
  logic             level_nxt;
  logic             press_q;
  logic             press_nxt;
  logic             release_q;
  logic             release_nxt;

  // Plain two-flop synchroniser: nothing may sit between these stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= bif.btn;
      btn_sync <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt < CNT_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt < CNT_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so it moves on the same edge as the pulses.
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  assign bif.btn_level   = level_q;
  assign bif.btn_press   = press_q;
  assign bif.btn_release = release_q;

endmodule
